// File: rtl/map_ss_engine_pkg.sv
// Shared definitions for the mapper save-state engine: state encoding and
// parameter defaults.
package map_ss_engine_pkg;

    localparam int unsigned SS_LEN_DEFAULT   = 128;
    localparam logic [15:0] BUF_BASE_DEFAULT = 16'h0000;

    typedef enum logic [3:0] {
        IDLE,
        S_SET,
        S_WAIT,
        S_STORE,
        L_FETCH,
        L_SET,
        L_WAIT,
        L_REL,
        FIN
    } ss_state_e;

endpackage

// File: rtl/map_ss_engine_if.sv
// Save-state bus between the engine, the mapper register file and the buffer RAM.
interface map_ss_engine_if;

    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic [15:0] buf_addr;
    logic [7:0] buf_wdat;
    logic       buf_we;
    logic [7:0] buf_rdat;

    modport master (
        output ss_act, ss_we, ss_addr, ss_wdat, buf_addr, buf_wdat, buf_we,
        input  ss_rdat, buf_rdat
    );

    modport slave (
        input  ss_act, ss_we, ss_addr, ss_wdat, buf_addr, buf_wdat, buf_we,
        output ss_rdat, buf_rdat
    );

endinterface

// File: rtl/map_ss_engine_m2_edge_sync.sv
// Brings the cartridge M2 clock into the clk domain and flags its falling edge.
module m2_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic m2,
    output logic m2_fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    always_comb begin
        sync1_d = m2;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign m2_fall = prev_q & ~sync2_q;

endmodule

// File: rtl/map_ss_engine.sv
// Save-state transfer engine: copies mapper registers to/from a buffer, one
// byte per M2 falling edge. Define SS_CHKSUM_EN to enable the running checksum.
module map_ss_engine
    import map_ss_engine_pkg::*;
#(
    parameter int unsigned SS_LEN   = SS_LEN_DEFAULT,
    parameter logic [15:0] BUF_BASE = BUF_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m2,
    input  logic                  start_save,
    input  logic                  start_load,
    map_ss_engine_if.master       bus,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           chksum
);

    localparam logic [8:0] LAST_IDX = 9'(SS_LEN - 1);

    logic        m2_fall;
    ss_state_e   state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic        ss_act_q, ss_act_d;
    logic        ss_we_q, ss_we_d;
    logic [7:0]  ss_wdat_q, ss_wdat_d;
    logic        buf_we_q, buf_we_d;
    logic [7:0]  buf_wdat_q, buf_wdat_d;
    logic [15:0] buf_addr_q, buf_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    m2_edge_sync u_m2_sync (
        .clk     (clk),
        .rst     (rst),
        .m2      (m2),
        .m2_fall (m2_fall)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ss_we_d    = ss_we_q;
        ss_wdat_d  = ss_wdat_q;
        buf_we_d   = 1'b0;
        buf_wdat_d = buf_wdat_q;
        case (state_q)
            IDLE: begin
                if (start_save) begin
                    state_d = S_SET;
                    idx_d   = '0;
                end else if (start_load) begin
                    state_d = L_FETCH;
                    idx_d   = '0;
                end
            end
            S_SET:   state_d = S_WAIT;
            S_WAIT: begin
                if (m2_fall) begin
                    state_d    = S_STORE;
                    buf_we_d   = 1'b1;
                    buf_wdat_d = bus.ss_rdat;
                end
            end
            S_STORE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 9'd1;
                    state_d = S_SET;
                end
            end
            L_FETCH: state_d = L_SET;
            L_SET: begin
                state_d   = L_WAIT;
                ss_wdat_d = bus.buf_rdat;
            end
            // ss_we rises one clk after ss_wdat settles so the two never switch
            // together; only a fall seen while the strobe is up completes the byte.
            L_WAIT: begin
                if (ss_we_q && m2_fall) begin
                    state_d = L_REL;
                    ss_we_d = 1'b0;
                end else begin
                    ss_we_d = 1'b1;
                end
            end
            L_REL: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 9'd1;
                    state_d = L_FETCH;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        ss_act_d   = busy_d && (state_d != FIN);
        done_d     = (state_d == FIN);
        buf_addr_d = BUF_BASE + {7'd0, idx_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ss_act_q   <= 1'b0;
            ss_we_q    <= 1'b0;
            ss_wdat_q  <= '0;
            buf_we_q   <= 1'b0;
            buf_wdat_q <= '0;
            buf_addr_q <= BUF_BASE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ss_act_q   <= ss_act_d;
            ss_we_q    <= ss_we_d;
            ss_wdat_q  <= ss_wdat_d;
            buf_we_q   <= buf_we_d;
            buf_wdat_q <= buf_wdat_d;
            buf_addr_q <= buf_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef SS_CHKSUM_EN
    logic [15:0] chksum_q, chksum_d;

    always_comb begin
        chksum_d = chksum_q;
        case (state_q)
            IDLE:    if (start_save || start_load) chksum_d = '0;
            S_STORE: chksum_d = chksum_q + {8'd0, bus.ss_rdat};
            L_REL:   chksum_d = chksum_q + {8'd0, ss_wdat_q};
            default: chksum_d = chksum_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chksum_q <= '0;
        else     chksum_q <= chksum_d;
    end

    assign chksum = chksum_q;
`else
    assign chksum = '0;
`endif

    assign bus.ss_act   = ss_act_q;
    assign bus.ss_we    = ss_we_q;
    assign bus.ss_addr  = idx_q[7:0];
    assign bus.ss_wdat  = ss_wdat_q;
    assign bus.buf_we   = buf_we_q;
    assign bus.buf_wdat = buf_wdat_q;
    assign bus.buf_addr = buf_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_map_ss_engine.sv
// Bench for map_ss_engine: a 4-byte instance at a wrapping buffer base and a
// 256-byte instance, with mapper and buffer RAM models and a write scoreboard.
module tb_map_ss_engine;

    localparam int unsigned LEN_A  = 4;
    localparam logic [15:0] BASE_A = 16'hFFFE;
    localparam int unsigned LEN_B  = 256;
    localparam logic [15:0] BASE_B = 16'h0100;

    typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [7:0] addr; logic [7:0] data; } ld_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m2_gen = 1'b1;
    logic m2_hold = 1'b0;
    logic m2;
    logic start_save_a = 1'b0, start_load_a = 1'b0;
    logic start_save_b = 1'b0, start_load_b = 1'b0;
    logic busy_a, done_a, busy_b, done_b;
    logic [15:0] chksum_a, chksum_b;

    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = '0;
    logic [7:0]  poke_data = '0;
    logic [7:0]  mem_a [0:65535];
    logic [7:0]  mem_b [0:65535];
    logic [7:0]  map_reg_a [0:255];
    logic [7:0]  fall_addr [0:1023];
    logic [7:0]  fall_data [0:1023];
    int unsigned fall_cnt = 0;
    int unsigned ld_rd = 0;

    wr_t exp_wr_a[$];
    wr_t exp_wr_b[$];
    ld_t exp_ld[$];
    int  checks = 0;
    int  passes = 0;

    map_ss_engine_if if_a ();
    map_ss_engine_if if_b ();

    assign m2 = m2_hold | m2_gen;

    map_ss_engine #(.SS_LEN(LEN_A), .BUF_BASE(BASE_A)) dut_a (
        .clk(clk), .rst(rst), .m2(m2), .start_save(start_save_a), .start_load(start_load_a),
        .bus(if_a), .busy(busy_a), .done(done_a), .chksum(chksum_a)
    );

    map_ss_engine #(.SS_LEN(LEN_B), .BUF_BASE(BASE_B)) dut_b (
        .clk(clk), .rst(rst), .m2(m2), .start_save(start_save_b), .start_load(start_load_b),
        .bus(if_b), .busy(busy_b), .done(done_b), .chksum(chksum_b)
    );

    always #5 clk = ~clk;

    // M2 edges land on even ns, clk rising edges on odd ns.
    initial begin
        #2;
        forever begin
            m2_gen = ~m2_gen;
            #96;
        end
    end

    assign if_a.ss_rdat = if_a.ss_addr ^ 8'hA5;
    assign if_b.ss_rdat = if_b.ss_addr ^ 8'hA5;

    always @(posedge clk) begin
        if_a.buf_rdat <= mem_a[if_a.buf_addr];
        if (if_a.buf_we) mem_a[if_a.buf_addr] <= if_a.buf_wdat;
        if (poke_en) mem_a[poke_addr] <= poke_data;
        if_b.buf_rdat <= mem_b[if_b.buf_addr];
        if (if_b.buf_we) mem_b[if_b.buf_addr] <= if_b.buf_wdat;
    end

    // Mapper model: latches restore data on the M2 falling edge.
    always @(negedge m2) begin
        if (if_a.ss_we === 1'b1 && fall_cnt < 1024) begin
            map_reg_a[if_a.ss_addr] <= if_a.ss_wdat;
            fall_addr[fall_cnt]     <= if_a.ss_addr;
            fall_data[fall_cnt]     <= if_a.ss_wdat;
            fall_cnt                <= fall_cnt + 1;
        end
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic push_save_a();
        wr_t e;
        for (int unsigned i = 0; i < LEN_A; i++) begin
            e.addr = 16'(BASE_A + i);
            e.data = 8'(i) ^ 8'hA5;
            exp_wr_a.push_back(e);
        end
    endtask

    // Steps the clock until a transfer completes, scoring buffer writes,
    // restore strobes and mapper writes as they happen.
    task automatic run_xfer(input bit sel_b, input int unsigned budget,
                            output int unsigned writes, output int unsigned windows,
                            output int unsigned dones, output logic [7:0] last_addr);
        logic p_we, c_bwe, c_done, c_busy;
        logic [7:0] p_addr, p_wdat, c_saddr, c_bwdat;
        logic [15:0] c_baddr;
        int unsigned win_falls;
        bit finished;
        wr_t e;
        ld_t l;
        writes = 0; windows = 0; dones = 0; last_addr = '0; finished = 0;
        p_we = if_a.ss_we; p_addr = if_a.ss_addr; p_wdat = if_a.ss_wdat;
        win_falls = fall_cnt;
        for (int unsigned cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk);
            c_bwe   = sel_b ? if_b.buf_we   : if_a.buf_we;
            c_baddr = sel_b ? if_b.buf_addr : if_a.buf_addr;
            c_bwdat = sel_b ? if_b.buf_wdat : if_a.buf_wdat;
            c_saddr = sel_b ? if_b.ss_addr  : if_a.ss_addr;
            c_done  = sel_b ? done_b : done_a;
            c_busy  = sel_b ? busy_b : busy_a;
            if (c_bwe === 1'b1) begin
                writes++;
                last_addr = c_saddr;
                checks++;
                if ((sel_b ? exp_wr_b.size() : exp_wr_a.size()) == 0) begin
                    $display("FAIL buf_write: got addr=%h data=%h, required no write", c_baddr, c_bwdat);
                end else begin
                    e = sel_b ? exp_wr_b.pop_front() : exp_wr_a.pop_front();
                    if ({c_baddr, c_bwdat} !== {e.addr, e.data})
                        $display("FAIL buf_write: got addr=%h data=%h, required addr=%h data=%h",
                                 c_baddr, c_bwdat, e.addr, e.data);
                    else passes++;
                end
            end
            if (c_done === 1'b1) dones++;
            if (dones > 0 && c_busy === 1'b0) finished = 1;
            if (!sel_b) begin
                if (p_we === 1'b1 || if_a.ss_we === 1'b1) begin
                    checks++;
                    if (if_a.ss_addr !== p_addr || if_a.ss_wdat !== p_wdat)
                        $display("FAIL ss_we_stable: addr %h->%h wdat %h->%h, required unchanged",
                                 p_addr, if_a.ss_addr, p_wdat, if_a.ss_wdat);
                    else passes++;
                end
                if (p_we !== 1'b1 && if_a.ss_we === 1'b1) begin
                    windows++;
                    win_falls = fall_cnt;
                end
                if (p_we === 1'b1 && if_a.ss_we !== 1'b1) begin
                    checks++;
                    if (fall_cnt == win_falls)
                        $display("FAIL ss_we_window: got 0 m2 falls inside window, required >=1");
                    else passes++;
                end
                p_we = if_a.ss_we; p_addr = if_a.ss_addr; p_wdat = if_a.ss_wdat;
            end
            while (ld_rd < fall_cnt) begin
                checks++;
                if (exp_ld.size() == 0) begin
                    $display("FAIL mapper_write: got reg %h=%h, required no write",
                             fall_addr[ld_rd], fall_data[ld_rd]);
                end else begin
                    l = exp_ld.pop_front();
                    if ({fall_addr[ld_rd], fall_data[ld_rd]} !== {l.addr, l.data})
                        $display("FAIL mapper_write: got reg %h=%h, required reg %h=%h",
                                 fall_addr[ld_rd], fall_data[ld_rd], l.addr, l.data);
                    else passes++;
                end
                ld_rd++;
            end
        end
        if (!finished) begin
            checks++;
            $display("FAIL xfer_timeout: got no completion in %0d clks, required done then idle", budget);
        end
    endtask

    task automatic test_reset();
        logic [15:0] exp_ck;
        repeat (3) @(negedge clk);
        exp_ck = '0;
        checks++;
        if ({if_a.ss_act, if_a.ss_we, if_a.buf_we, busy_a, done_a} !== 5'b0)
            $display("FAIL reset_ctrl_a: got %b, required 00000",
                     {if_a.ss_act, if_a.ss_we, if_a.buf_we, busy_a, done_a});
        else passes++;
        checks++;
        if ({if_a.ss_addr, if_a.ss_wdat} !== 16'h0000)
            $display("FAIL reset_ss_a: got addr=%h wdat=%h, required 00 00", if_a.ss_addr, if_a.ss_wdat);
        else passes++;
        checks++;
        if (if_a.buf_addr !== BASE_A)
            $display("FAIL reset_buf_addr_a: got %h, required %h", if_a.buf_addr, BASE_A);
        else passes++;
        checks++;
        if (if_b.buf_addr !== BASE_B)
            $display("FAIL reset_buf_addr_b: got %h, required %h", if_b.buf_addr, BASE_B);
        else passes++;
        checks++;
        if (chksum_a !== exp_ck || chksum_b !== exp_ck)
            $display("FAIL reset_chksum: got %h/%h, required 0000", chksum_a, chksum_b);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, busy_b, if_a.ss_act, if_b.ss_act} !== 4'b0)
            $display("FAIL idle_after_reset: got %b, required 0000", {busy_a, busy_b, if_a.ss_act, if_b.ss_act});
        else passes++;
    endtask

    task automatic test_save();
        int unsigned w, win, d;
        logic [7:0] la;
        logic [15:0] sum;
        for (int unsigned i = 0; i < LEN_A; i++) poke(16'(BASE_A + i), 8'h00);
        push_save_a();
        sum = '0;
        for (int unsigned i = 0; i < LEN_A; i++) sum = sum + {8'd0, 8'(i) ^ 8'hA5};
`ifndef SS_CHKSUM_EN
        sum = '0;
`endif
        @(negedge clk); start_save_a = 1'b1;
        @(negedge clk); start_save_a = 1'b0;
        run_xfer(1'b0, 400, w, win, d, la);
        checks++;
        if (w != LEN_A || d != 1 || win != 0)
            $display("FAIL save_counts: got writes=%0d dones=%0d windows=%0d, required 4 1 0", w, d, win);
        else passes++;
        for (int unsigned i = 0; i < LEN_A; i++) begin
            checks++;
            if (mem_a[16'(BASE_A + i)] !== (8'(i) ^ 8'hA5))
                $display("FAIL save_mem[%0d]: got %h, required %h", i, mem_a[16'(BASE_A + i)], 8'(i) ^ 8'hA5);
            else passes++;
        end
        checks++;
        if (chksum_a !== sum) $display("FAIL save_chksum: got %h, required %h", chksum_a, sum);
        else passes++;
    endtask

    task automatic test_load();
        int unsigned w, win, d;
        logic [7:0] la;
        logic [7:0] data [0:3];
        logic [15:0] sum;
        ld_t l;
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
        sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            poke(16'(BASE_A + i), data[i]);
            l.addr = 8'(i); l.data = data[i];
            exp_ld.push_back(l);
            sum = sum + {8'd0, data[i]};
        end
`ifndef SS_CHKSUM_EN
        sum = '0;
`endif
        @(posedge m2_gen);
        @(negedge clk); start_load_a = 1'b1;
        @(negedge clk); start_load_a = 1'b0;
        run_xfer(1'b0, 400, w, win, d, la);
        checks++;
        if (win != 4 || w != 0 || d != 1)
            $display("FAIL load_counts: got windows=%0d writes=%0d dones=%0d, required 4 0 1", win, w, d);
        else passes++;
        for (int unsigned i = 0; i < 4; i++) begin
            checks++;
            if (map_reg_a[i] !== data[i])
                $display("FAIL load_reg[%0d]: got %h, required %h", i, map_reg_a[i], data[i]);
            else passes++;
        end
        checks++;
        if (chksum_a !== sum) $display("FAIL load_chksum: got %h, required %h", chksum_a, sum);
        else passes++;
    endtask

    task automatic test_start_priority();
        int unsigned w, win, d, busy_cnt;
        logic [7:0] la;
        push_save_a();
        @(negedge clk); start_save_a = 1'b1; start_load_a = 1'b1;
        @(negedge clk); start_save_a = 1'b0; start_load_a = 1'b0;
        repeat (2) @(negedge clk);
        start_load_a = 1'b1;
        @(negedge clk); start_load_a = 1'b0;
        run_xfer(1'b0, 400, w, win, d, la);
        checks++;
        if (w != LEN_A || win != 0 || d != 1)
            $display("FAIL priority_counts: got writes=%0d windows=%0d dones=%0d, required 4 0 1", w, win, d);
        else passes++;
        busy_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy_a === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 0) $display("FAIL busy_start_ignored: got %0d busy clks, required 0", busy_cnt);
        else passes++;
    endtask

    task automatic test_reset_abort();
        int unsigned w, win, d, done_cnt;
        logic [7:0] la;
        bit seen;
        for (int unsigned i = 0; i < LEN_A; i++) poke(16'(BASE_A + i), 8'h00);
        @(negedge clk); start_save_a = 1'b1;
        @(negedge clk); start_save_a = 1'b0;
        seen = 0;
        done_cnt = 0;
        for (int unsigned cyc = 0; cyc < 300 && !seen; cyc++) begin
            @(negedge clk);
            if (done_a === 1'b1) done_cnt++;
            if (if_a.ss_addr === 8'd2 && busy_a === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) $display("FAIL abort_reach_idx2: got no idx=2 within 300 clks, required idx=2");
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({if_a.ss_act, if_a.buf_we, busy_a, done_a, if_a.ss_addr} !== 12'h000)
            $display("FAIL abort_async_reset: got act=%b we=%b busy=%b done=%b addr=%h, required all 0",
                     if_a.ss_act, if_a.buf_we, busy_a, done_a, if_a.ss_addr);
        else passes++;
        checks++;
        if (if_a.buf_addr !== BASE_A || chksum_a !== 16'h0000)
            $display("FAIL abort_reset_addr: got buf_addr=%h chksum=%h, required %h 0000",
                     if_a.buf_addr, chksum_a, BASE_A);
        else passes++;
        @(negedge clk); rst = 1'b0;
        checks++;
        if ({mem_a[BASE_A], mem_a[16'(BASE_A + 1)], mem_a[16'(BASE_A + 2)]} !== 24'hA5A400)
            $display("FAIL abort_retained: got %h%h%h, required a5a400",
                     mem_a[BASE_A], mem_a[16'(BASE_A + 1)], mem_a[16'(BASE_A + 2)]);
        else passes++;
        repeat (30) begin
            @(negedge clk);
            if (done_a === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) $display("FAIL abort_no_done: got %0d done pulses, required 0", done_cnt);
        else passes++;
        push_save_a();
        @(negedge clk); start_save_a = 1'b1;
        @(negedge clk); start_save_a = 1'b0;
        run_xfer(1'b0, 400, w, win, d, la);
        checks++;
        if (w != LEN_A || d != 1)
            $display("FAIL abort_restart: got writes=%0d dones=%0d, required 4 1", w, d);
        else passes++;
    endtask

    task automatic test_m2_stall();
        int unsigned w, win, d, frozen;
        logic [7:0] la;
        m2_hold = 1'b1;
        repeat (5) @(negedge clk);
        push_save_a();
        @(negedge clk); start_save_a = 1'b1;
        @(negedge clk); start_save_a = 1'b0;
        repeat (3) @(negedge clk);
        frozen = 0;
        repeat (1000) begin
            @(negedge clk);
            if (busy_a === 1'b1 && if_a.ss_act === 1'b1 && if_a.ss_addr === 8'h00 &&
                if_a.buf_we === 1'b0 && done_a === 1'b0 && if_a.buf_addr === BASE_A)
                frozen++;
        end
        checks++;
        if (frozen != 1000) $display("FAIL stall_frozen: got %0d frozen clks, required 1000", frozen);
        else passes++;
        m2_hold = 1'b0;
        run_xfer(1'b0, 400, w, win, d, la);
        checks++;
        if (w != LEN_A || d != 1)
            $display("FAIL stall_resume: got writes=%0d dones=%0d, required 4 1", w, d);
        else passes++;
    endtask

    task automatic test_len256();
        int unsigned w, win, d, extra;
        logic [7:0] la;
        logic [15:0] sum;
        wr_t e;
        sum = '0;
        for (int unsigned i = 0; i < LEN_B; i++) begin
            e.addr = 16'(BASE_B + i);
            e.data = 8'(i) ^ 8'hA5;
            exp_wr_b.push_back(e);
            sum = sum + {8'd0, e.data};
        end
`ifndef SS_CHKSUM_EN
        sum = '0;
`endif
        @(negedge clk); start_save_b = 1'b1;
        @(negedge clk); start_save_b = 1'b0;
        run_xfer(1'b1, 9000, w, win, d, la);
        checks++;
        if (w != LEN_B || d != 1)
            $display("FAIL len256_counts: got writes=%0d dones=%0d, required 256 1", w, d);
        else passes++;
        checks++;
        if (la !== 8'hFF) $display("FAIL len256_last_addr: got %h, required ff", la);
        else passes++;
        checks++;
        if (chksum_b !== sum) $display("FAIL len256_chksum: got %h, required %h", chksum_b, sum);
        else passes++;
        extra = 0;
        repeat (60) begin
            @(negedge clk);
            if (if_b.buf_we === 1'b1 || busy_b === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) $display("FAIL len256_no_wrap: got %0d active clks after done, required 0", extra);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_save();
        test_load();
        test_start_priority();
        test_reset_abort();
        test_m2_stall();
        test_len256();
        checks++;
        if (exp_wr_a.size() != 0 || exp_wr_b.size() != 0 || exp_ld.size() != 0)
            $display("FAIL scoreboard_drain: got %0d/%0d/%0d entries left, required 0/0/0",
                     exp_wr_a.size(), exp_wr_b.size(), exp_ld.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
